// File: rtl/lsu.sv
// Load/store unit: one outstanding memory access, byte/half/word lanes, sign/zero-extended loads.
// Optional macro LSU_MISALIGN_CHECK_EN turns misaligned H/W accesses into an error response.
module lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [ADDR_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] StoreData,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  misalign_err,
    output logic [1:0]            o_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_RESP     = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_t                r_state;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [1:0]            r_lane;
    logic                  r_misalign;

    logic                  w_accept;
    logic [1:0]            w_size;
    logic [1:0]            w_lane;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_misalign;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load;

    // Handshake: a request transfers on a rising edge where req_valid & req_ready and
    // MemRead|MemWrite are all high; req_ready is high only while idle.
    assign req_ready    = (r_state == S_IDLE);
    assign w_accept     = req_valid & req_ready & (MemRead | MemWrite);
    assign w_lane       = ALUResult[1:0];
    assign misalign_err = r_misalign;
    assign o_state      = r_state;

    always_comb begin
        w_size = SZ_W;
        case (Funct3)
            3'b000, 3'b100: w_size = SZ_B;
            3'b001, 3'b101: w_size = SZ_H;
            default:        w_size = SZ_W;
        endcase
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = StoreData;
        case (w_size)
            SZ_B: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{StoreData[7:0]}};
            end
            SZ_H: begin
                w_be    = 4'b0011 << {w_lane[1], 1'b0};
                w_wdata = {2{StoreData[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = StoreData;
            end
        endcase
    end

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_misalign = ((w_size == SZ_H) & w_lane[0]) |
                        ((w_size == SZ_W) & (w_lane != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Lane extraction uses the registered offset; halfword ignores addr[0].
    assign w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
    assign w_half = mem_rdata[{r_lane[1], 4'b0000} +: 16];

    always_comb begin
        w_load = mem_rdata;
        case (r_size)
            SZ_B:    w_load = r_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_H:    w_load = r_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_size     <= SZ_W;
            r_unsigned <= 1'b0;
            r_lane     <= 2'b00;
            r_misalign <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= 4'b0000;
            resp_valid <= 1'b0;
            ReadData   <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_size     <= w_size;
                        r_unsigned <= Funct3[2];
                        r_lane     <= w_lane;
                        mem_we     <= MemWrite;
                        mem_addr   <= {ALUResult[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata  <= w_wdata;
                        mem_be     <= w_be;
                        if (w_misalign) begin
                            r_misalign <= 1'b1;
                            resp_valid <= 1'b1;
                            r_state    <= S_RESP;
                        end else begin
                            mem_req    <= 1'b1;
                            r_state    <= S_WAIT_ACK;
                        end
                    end
                end
                S_WAIT_ACK: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        if (!mem_we) begin
                            ReadData <= w_load;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_misalign <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, datapath width; only 32 is supported.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have req_valid  input  1  execute stage presents a memory operation.
REQ-006 SHALL have req_ready  output  1  LSU can accept a request this cycle.
REQ-007 SHALL have MemRead  input  1  load request.
REQ-008 SHALL have MemWrite  input  1  store request.
REQ-009 SHALL have Funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL have ALUResult  input  ADDR_WIDTH  effective byte address from the ALU.
REQ-011 SHALL have StoreData  input  DATA_WIDTH  rs2 value for stores.
REQ-012 SHALL have mem_req  output  1  memory request, held until mem_ack.
REQ-013 SHALL have mem_we  output  1  memory write enable.
REQ-014 SHALL have mem_addr  output  ADDR_WIDTH  word-aligned address (bits[1:0]=00).
REQ-015 SHALL have mem_wdata  output  DATA_WIDTH  lane-shifted store data.
REQ-016 SHALL have mem_be  output  4  byte enables.
REQ-017 SHALL have mem_rdata  input  DATA_WIDTH  read word, valid with mem_ack.
REQ-018 SHALL have mem_ack  input  1  one-cycle access completion.
REQ-019 SHALL have resp_valid  output  1  one-cycle completion pulse.
REQ-020 SHALL have ReadData  output  DATA_WIDTH  extended load result, held until the next response.
REQ-021 SHALL have misalign_err  output  1  qualifies resp_valid; the access was misaligned.

Function
REQ-022 SHALL implement FSM IDLE, WAIT_ACK, RESP; req_ready=1 only in IDLE.
REQ-023 SHALL accept a request when req_valid & req_ready & (MemRead|MemWrite); req_valid alone is ignored.
REQ-024 SHALL treat MemRead & MemWrite both high as a store.
REQ-025 SHALL treat unsupported Funct3 (011, 110, 111) as word access.
REQ-026 SHALL on accept register the address, size, sign, data and direction, then go to WAIT_ACK with mem_req=1 from the next cycle.
REQ-027 SHALL hold mem_req, mem_we, mem_addr, mem_wdata and mem_be stable in WAIT_ACK until mem_ack.
REQ-028 SHALL generate mem_be: B = 0001<<addr[1:0]; H = 0011<<{addr[1],0}; W = 1111; loads drive the same mask.
REQ-029 SHALL replicate StoreData into the selected lanes: byte at bits 8*addr[1:0], half at bits 16*addr[1].
REQ-030 SHALL on mem_ack in WAIT_ACK drop mem_req the next cycle, extract the lane from mem_rdata, sign-extend (B, H) or zero-extend (BU, HU), update ReadData and enter RESP.
REQ-031 SHALL pulse resp_valid for exactly one cycle in RESP, then return to IDLE; stores also pulse and leave ReadData unchanged.
REQ-032 SHALL give minimum latency of accept to resp_valid = 3 cycles with zero-wait mem_ack.
REQ-033 SHALL ignore mem_ack outside WAIT_ACK.

Reset
REQ-034 SHALL force state IDLE, req_ready=1, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, resp_valid=0, ReadData=0, misalign_err=0 while reset is high, including mid-transaction; the aborted access produces no response.

Configuration
REQ-035 SHALL with LSU_MISALIGN_CHECK_EN defined flag H/HU at odd addresses and W with addr[1:0]!=0: no memory access, RESP next cycle with resp_valid=1, misalign_err=1, ReadData unchanged.
REQ-036 SHALL without LSU_MISALIGN_CHECK_EN align misaligned accesses down (H: addr[0] ignored, W: addr[1:0] ignored), perform them normally, and tie misalign_err to 0.

Verification
REQ-037 SHALL include a test where LB at 0x103 with mem_rdata=0x80FF_1234 -> mem_be=1000, ReadData=0xFFFF_FF80.
REQ-038 SHALL include a test where LHU at 0x102 with mem_rdata=0xBEEF_0000 -> mem_be=1100, ReadData=0x0000_BEEF.
REQ-039 SHALL include a test where SB at 0x201 with StoreData=0x0000_00AB -> mem_we=1, mem_addr=0x200, mem_be=0010, mem_wdata=0xABAB_ABAB, resp_valid pulse.
REQ-040 SHALL include a test where LW at 0x40 with mem_ack delayed 4 cycles -> mem_req held 4 cycles with outputs stable, req_ready=0 throughout, single resp_valid.
REQ-041 SHALL include a test where LW at 0x42 -> with macro: no mem_req, misalign_err=1; without macro: mem_addr=0x40, misalign_err=0.
REQ-042 SHALL include a test where reset is asserted in WAIT_ACK -> mem_req=0 immediately, no resp_valid, next request is accepted normally.
